// File: rtl/fsm_supervisor_mc.sv
// -----------------------------------------------------------------------------
// fsm_supervisor_mc
//
// Multi-channel job supervisor. Every channel runs its own start/done/fault
// control FSM with a sticky error state that needs an explicit clear and a
// 2-bit cause code. Channels share nothing: each one is a separate generate
// instance.
//
// Optional feature macro: FSM_SUP_WATCHDOG_EN
//   defined     -> BUSY watchdog (TIMEOUT_CYC) with bounded retry (MAX_RETRY),
//                  RETRY state and timeout cause code 2'b10.
//   not defined -> BUSY waits indefinitely for done/fault, RETRY unreachable,
//                  only cause codes 00/01. TIMEOUT_CYC and MAX_RETRY unused.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   in_start    [N_CH]    start request per channel (level, sampled in IDLE)
//   in_done     [N_CH]    completion per channel
//   in_fault    [N_CH]    fault per channel
//   in_clear    [N_CH]    error acknowledge per channel
//   out_busy    [N_CH]    1 in BUSY or RETRY
//   out_error   [N_CH]    1 in ERROR
//   out_done    [N_CH]    1 in DONE (single-cycle pulse)
//   any_error   OR of out_error
//   err_code_q  [2*N_CH]  ch i at [2i+1:2i]: 00 none, 01 fault, 10 timeout
//   state_q     [3*N_CH]  ch i at [3i+2:3i]: IDLE 0, BUSY 1, DONE 2,
//                         RETRY 3, ERROR 4
//
// All outputs decode registered state only; no input-to-output path.
// -----------------------------------------------------------------------------
module fsm_supervisor_mc #(
  parameter int N_CH        = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_start,
  input  logic [N_CH-1:0]     in_done,
  input  logic [N_CH-1:0]     in_fault,
  input  logic [N_CH-1:0]     in_clear,
  output logic [N_CH-1:0]     out_busy,
  output logic [N_CH-1:0]     out_error,
  output logic [N_CH-1:0]     out_done,
  output logic                any_error,
  output logic [2*N_CH-1:0]   err_code_q,
  output logic [3*N_CH-1:0]   state_q
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUSY  = 3'd1,
    S_DONE  = 3'd2,
    S_RETRY = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_FAULT   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // Elaboration-time guard on the parameter ranges the logic relies on.
  if (N_CH < 1 || TIMEOUT_CYC < 1 || MAX_RETRY < 0) begin : g_bad_params
    $error("fsm_supervisor_mc: N_CH>=1, TIMEOUT_CYC>=1, MAX_RETRY>=0 required");
  end

`ifdef FSM_SUP_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // A zero-width counter is illegal, so MAX_RETRY=0 still gets one bit.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t     state, next_state;
    logic [1:0] code, next_code;
`ifdef FSM_SUP_WATCHDOG_EN
    logic [TW-1:0] timer, next_timer;
    logic [RW-1:0] retry, next_retry;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_IDLE;
        code  <= CODE_NONE;
`ifdef FSM_SUP_WATCHDOG_EN
        timer <= '0;
        retry <= '0;
`endif
      end else begin
        state <= next_state;
        code  <= next_code;
`ifdef FSM_SUP_WATCHDOG_EN
        timer <= next_timer;
        retry <= next_retry;
`endif
      end
    end

    // NOTE: every next_* signal is given its hold value first so no path
    // through the case statement leaves it unassigned (which would infer a latch).
    always_comb begin
      next_state = state;
      next_code  = code;
`ifdef FSM_SUP_WATCHDOG_EN
      next_timer = timer;
      next_retry = retry;
`endif
      unique case (state)
        S_IDLE: begin
          if (in_start[i]) begin
            next_state = S_BUSY;
`ifdef FSM_SUP_WATCHDOG_EN
            next_timer = TIMER_LOAD;
            next_retry = '0;
`endif
          end
        end
        S_BUSY: begin
          // Priority: fault > done > timeout.
          if (in_fault[i]) begin
            next_state = S_ERROR;
            next_code  = CODE_FAULT;
          end else if (in_done[i]) begin
            next_state = S_DONE;
`ifdef FSM_SUP_WATCHDOG_EN
          end else if (timer == '0) begin
            if (retry < RETRY_MAX) begin
              next_state = S_RETRY;
            end else begin
              next_state = S_ERROR;
              next_code  = CODE_TIMEOUT;
            end
          end else begin
            next_timer = timer - TW'(1);
`endif
          end
        end
        S_DONE: next_state = S_IDLE;
        S_ERROR: begin
          // Start is deliberately ignored here, even in the clear cycle.
          if (in_clear[i] && !in_fault[i]) begin
            next_state = S_IDLE;
            next_code  = CODE_NONE;
          end
        end
`ifdef FSM_SUP_WATCHDOG_EN
        S_RETRY: begin
          // done during RETRY is ignored; only fault can divert the retry.
          if (in_fault[i]) begin
            next_state = S_ERROR;
            next_code  = CODE_FAULT;
          end else begin
            next_state = S_BUSY;
            next_timer = TIMER_LOAD;
            next_retry = retry + RW'(1);
          end
        end
`endif
        default: begin
          // Illegal encodings (and RETRY without the watchdog) recover to IDLE.
          next_state = S_IDLE;
          next_code  = CODE_NONE;
        end
      endcase
    end

    assign out_busy[i]           = (state == S_BUSY) || (state == S_RETRY);
    assign out_error[i]          = (state == S_ERROR);
    assign out_done[i]           = (state == S_DONE);
    assign err_code_q[2*i +: 2]  = code;
    assign state_q[3*i +: 3]     = state;
  end

  assign any_error = |out_error;

endmodule

// File: tb/tb_fsm_supervisor_mc.sv
// -----------------------------------------------------------------------------
// tb_fsm_supervisor_mc
//
// Directed bench for fsm_supervisor_mc with N_CH=2, TIMEOUT_CYC=8, MAX_RETRY=2.
// Inputs are driven 1 ns after a rising edge and outputs are sampled 1 ns after
// the following rising edge. Watchdog scenarios are built only when
// FSM_SUP_WATCHDOG_EN is defined; the indefinite-BUSY scenario only when not.
// -----------------------------------------------------------------------------
module tb_fsm_supervisor_mc;

  localparam int N_CH = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BUSY  = 3'd1;
  localparam logic [2:0] DONE  = 3'd2;
  localparam logic [2:0] RETRY = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   in_start = '0;
  logic [N_CH-1:0]   in_done  = '0;
  logic [N_CH-1:0]   in_fault = '0;
  logic [N_CH-1:0]   in_clear = '0;
  logic [N_CH-1:0]   out_busy;
  logic [N_CH-1:0]   out_error;
  logic [N_CH-1:0]   out_done;
  logic              any_error;
  logic [2*N_CH-1:0] err_code_q;
  logic [3*N_CH-1:0] state_q;

  int checks = 0;
  int errors = 0;

  fsm_supervisor_mc #(
    .N_CH        (N_CH),
    .TIMEOUT_CYC (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_start   (in_start),
    .in_done    (in_done),
    .in_fault   (in_fault),
    .in_clear   (in_clear),
    .out_busy   (out_busy),
    .out_error  (out_error),
    .out_done   (out_done),
    .any_error  (any_error),
    .err_code_q (err_code_q),
    .state_q    (state_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full per-channel view: state plus the three decoded flags and code.
  task automatic check_ch(input string tag, input int ch, input logic [2:0] st,
                          input logic [1:0] code);
    check({tag, " state"}, 32'(state_q[3*ch +: 3]), 32'(st));
    check({tag, " busy"},  32'(out_busy[ch]),  32'(st == BUSY || st == RETRY));
    check({tag, " error"}, 32'(out_error[ch]), 32'(st == ERROR));
    check({tag, " done"},  32'(out_done[ch]),  32'(st == DONE));
    check({tag, " code"},  32'(err_code_q[2*ch +: 2]), 32'(code));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state_q"},    32'(state_q),    32'd0);
    check({tag, " err_code_q"}, 32'(err_code_q), 32'd0);
    check({tag, " flags"},
          32'({out_busy, out_error, out_done, any_error}), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    #20;
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // 1: ch0 start 1 cycle, done in 3rd BUSY cycle -> 1,1,1,2,0
    in_start[0] = 1'b1;
    tick();
    check_ch("t1 c1", 0, BUSY, 2'b00);
    in_start[0] = 1'b0;
    tick();
    check_ch("t1 c2", 0, BUSY, 2'b00);
    tick();
    check_ch("t1 c3", 0, BUSY, 2'b00);
    in_done[0] = 1'b1;
    tick();
    check_ch("t1 c4", 0, DONE, 2'b00);
    in_done[0] = 1'b0;
    tick();
    check_ch("t1 c5", 0, IDLE, 2'b00);
    check("t1 ch1 idle", 32'(state_q[5:3]), 32'(IDLE));

    // DONE with start still held: DONE -> IDLE -> BUSY
    in_start[0] = 1'b1;
    tick();
    check_ch("held c1", 0, BUSY, 2'b00);
    in_done[0] = 1'b1;
    tick();
    check_ch("held done", 0, DONE, 2'b00);
    in_done[0] = 1'b0;
    tick();
    check_ch("held idle", 0, IDLE, 2'b00);
    tick();
    check_ch("held rebusy", 0, BUSY, 2'b00);
    in_start[0] = 1'b0;
    in_done[0]  = 1'b1;
    tick();
    in_done[0] = 1'b0;
    tick();
    check_ch("held back idle", 0, IDLE, 2'b00);

    // 3: ch1 done+fault together -> ERROR/01; clear with fault held ignored
    in_start[1] = 1'b1;
    tick();
    in_start[1] = 1'b0;
    check_ch("t3 busy", 1, BUSY, 2'b00);
    in_done[1]  = 1'b1;
    in_fault[1] = 1'b1;
    tick();
    check_ch("t3 err", 1, ERROR, 2'b01);
    check("t3 any_error", 32'(any_error), 32'd1);
    check_ch("t3 ch0 untouched", 0, IDLE, 2'b00);
    in_done[1]  = 1'b0;
    in_clear[1] = 1'b1;
    tick();
    check_ch("t3 clear+fault", 1, ERROR, 2'b01);
    in_fault[1] = 1'b0;
    tick();
    check_ch("t3 cleared", 1, IDLE, 2'b00);
    check("t3 any_error off", 32'(any_error), 32'd0);
    in_clear[1] = 1'b0;

    // 4: ch0 ERROR, start+clear together -> IDLE, then BUSY
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    in_fault[0] = 1'b1;
    tick();
    check_ch("t4 err", 0, ERROR, 2'b01);
    in_fault[0] = 1'b0;
    in_start[0] = 1'b1;
    tick();
    check_ch("t4 start ignored in err", 0, ERROR, 2'b01);
    in_clear[0] = 1'b1;
    tick();
    check_ch("t4 clear", 0, IDLE, 2'b00);
    in_clear[0] = 1'b0;
    tick();
    check_ch("t4 restart", 0, BUSY, 2'b00);
    in_start[0] = 1'b0;
    in_clear[0] = 1'b1;
    tick();
    check_ch("t4 clear outside err", 0, BUSY, 2'b00);
    in_clear[0] = 1'b0;
    in_done[0]  = 1'b1;
    tick();
    in_done[0] = 1'b0;
    tick();
    check_ch("t4 back idle", 0, IDLE, 2'b00);

    // 5: async reset mid-BUSY on both channels
    in_start = 2'b11;
    tick();
    in_start = 2'b00;
    tick();
    check("t5 both busy", 32'(state_q), 32'({BUSY, BUSY}));
    #2 rst = 1'b1;
    #1;
    check_all_zero("t5 async rst");
    tick();
    check_all_zero("t5 rst held");
    #2 rst = 1'b0;
    tick();
    check_all_zero("t5 released");

`ifdef FSM_SUP_WATCHDOG_EN
    // 5 (cont.): fresh start gets a full 8-cycle timeout
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int c = 1; c < 8; c++) begin
      tick();
      check("t5 busy run", 32'(state_q[2:0]), 32'(BUSY));
    end
    tick();
    check_ch("t5 first retry", 0, RETRY, 2'b00);
    // Abort via fault during RETRY -> ERROR/01
    in_fault[0] = 1'b1;
    in_done[0]  = 1'b1;
    tick();
    check_ch("t5 fault in retry", 0, ERROR, 2'b01);
    in_fault[0] = 1'b0;
    in_done[0]  = 1'b0;
    in_clear[0] = 1'b1;
    tick();
    in_clear[0] = 1'b0;
    check_ch("t5 cleared", 0, IDLE, 2'b00);

    // 2: no done -> BUSY8, RETRY, BUSY8, RETRY, BUSY8, ERROR/10
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (c != 0 || r != 0) tick();
        check($sformatf("t2 busy r%0d c%0d", r, c), 32'(state_q[2:0]), 32'(BUSY));
      end
      tick();
      if (r < 2) check_ch($sformatf("t2 retry r%0d", r), 0, RETRY, 2'b00);
    end
    check_ch("t2 timeout err", 0, ERROR, 2'b10);
    check("t2 any_error", 32'(any_error), 32'd1);
    in_clear[0] = 1'b1;
    tick();
    in_clear[0] = 1'b0;
    check_ch("t2 cleared", 0, IDLE, 2'b00);

    // done coinciding with timer==0 wins over the timeout
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("tz last busy", 32'(state_q[2:0]), 32'(BUSY));
    in_done[0] = 1'b1;
    tick();
    in_done[0] = 1'b0;
    check_ch("tz done at zero", 0, DONE, 2'b00);
    tick();
    check_ch("tz idle", 0, IDLE, 2'b00);
`else
    // 6: no watchdog -> BUSY indefinitely, then done
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      check($sformatf("t6 busy %0d", c),
            32'({state_q[2:0], out_error[0], err_code_q[1:0]}),
            32'({BUSY, 1'b0, 2'b00}));
    end
    in_done[0] = 1'b1;
    tick();
    in_done[0] = 1'b0;
    check_ch("t6 done", 0, DONE, 2'b00);
    tick();
    check_ch("t6 idle", 0, IDLE, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
